// File: rtl/axi_wr_rgb_pkg.sv
// Shared types and geometry helpers for the RGB565 FDMA write client.
package axi_wr_rgb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_WAIT,
    S_REQ,
    S_DATA
  } state_t;

  localparam int IRQ_LEN = 60;
  localparam int RST_LEN = 16;

  function automatic int pix_per_word(int dw, int pw);
    return dw / pw;
  endfunction

  function automatic int burst_words(int xs, int ppw, int xdiv);
    return xs / ppw / xdiv;
  endfunction

  function automatic int burst_inc(int xs, int xdiv);
    return xs * 2 / xdiv;
  endfunction

  function automatic int last_inc(int stride, int xs, int xdiv);
    return (stride - xs) * 2 + xs * 2 / xdiv;
  endfunction

endpackage

// File: rtl/wr_pix_pack.sv
// Packs narrow pixels into one wide word, pixel 0 in the LSBs.
module wr_pix_pack #(
  parameter int PIX_W  = 16,
  parameter int WORD_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              pix_vld_i,
  input  logic [PIX_W-1:0]  pix_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_vld_o
);

  localparam int PPW = WORD_W / PIX_W;
  localparam int IW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [IW-1:0] ILAST = IW'(PPW - 1);

  logic [IW-1:0]     idx_q;
  logic [WORD_W-1:0] word_q;
  logic              vld_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else if (clr_i) begin
      idx_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= pix_vld_i && (idx_q == ILAST);
      if (pix_vld_i) begin
        word_q[idx_q*PIX_W +: PIX_W] <= pix_i;
        idx_q <= (idx_q == ILAST) ? '0 : idx_q + 1'b1;
      end
    end
  end

  assign word_o     = word_q;
  assign word_vld_o = vld_q;

endmodule

// File: rtl/axi_wr_rgb_pack.sv
// RGB565 to FDMA write client with rotating frame buffers.
// Define AXI_WR_DECIM_EN to add the I_W_decim 2:1 decimation input.
module axi_wr_rgb_pack
  import axi_wr_rgb_pkg::*;
#(
  parameter int          AXI_DATA_WIDTH = 128,
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter int          W_DATAWIDTH    = 16,
  parameter logic [63:0] W_BASEADDR     = 64'd0,
  parameter int          W_DSIZEBITS    = 24,
  parameter int          W_XSIZE        = 1920,
  parameter int          W_XSTRIDE      = 1920,
  parameter int          W_YSIZE        = 1080,
  parameter int          W_XDIV         = 2,
  parameter int          W_BUFSIZE      = 3,
  parameter int          W_FIFO_DEPTH   = 512
) (
  input  logic                      I_ui_clk,
  input  logic                      I_ui_rst,
  input  logic                      I_W_FS,
`ifdef AXI_WR_DECIM_EN
  input  logic                      I_W_decim,
`endif
  input  logic                      I_W_wren,
  input  logic [W_DATAWIDTH-1:0]    I_W_data,
  output logic                      O_W_ovf,
  output logic [7:0]                O_W_sync_cnt,
  input  logic [7:0]                I_W_buf,
  output logic [AXI_ADDR_WIDTH-1:0] O_fdma_waddr,
  output logic                      O_fdma_wareq,
  output logic [15:0]               O_fdma_wsize,
  input  logic                      I_fdma_wbusy,
  output logic [AXI_DATA_WIDTH-1:0] O_fdma_wdata,
  input  logic                      I_fdma_wvalid,
  output logic                      O_fdma_wready,
  output logic [7:0]                O_fmda_wbuf,
  output logic                      O_fdma_wirq
);

  localparam int PPW    = pix_per_word(AXI_DATA_WIDTH, W_DATAWIDTH);
  localparam int BURST  = burst_words(W_XSIZE, PPW, W_XDIV);
  localparam int BINC   = burst_inc(W_XSIZE, W_XDIV);
  localparam int LINC   = last_inc(W_XSTRIDE, W_XSIZE, W_XDIV);
  localparam int NBURST = W_YSIZE * W_XDIV;
  localparam int FA     = $clog2(W_FIFO_DEPTH);
  localparam int FC     = FA + 1;
  localparam logic [FA-1:0] FLAST = FA'(W_FIFO_DEPTH - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] DMASK =
    AXI_ADDR_WIDTH'((64'd1 << W_DSIZEBITS) - 64'd1);

  state_t state_q, state_d;
  logic fs_q, fs_rise, pend_q, fs_evt;
  logic [3:0] rcnt_q;
  logic [7:0] bufn_q, sync_q, wbuf_q, xdiv_q;
  logic [5:0] irq_q;
  logic [15:0] wsize_q, burst_w;
  logic [31:0] bcnt_q, nburst_w;
  logic [AXI_ADDR_WIDTH-1:0] waddr_q, binc_w, linc_w;
  logic keep, ovf_q, clr, pix_vld, word_vld;
  logic push, pop, full, empty, bdone, last_burst, xlast;
  logic [AXI_DATA_WIDTH-1:0] word;
  logic [AXI_DATA_WIDTH-1:0] mem_q [W_FIFO_DEPTH];
  logic [FA-1:0] wp_q, rp_q;
  logic [FC-1:0] cnt_q;

`ifdef AXI_WR_DECIM_EN
  logic [15:0] px_q;
  logic        ln_q;

  assign burst_w  = I_W_decim ? 16'(BURST / 2) : 16'(BURST);
  assign binc_w   = I_W_decim ? AXI_ADDR_WIDTH'(BINC / 2)
                              : AXI_ADDR_WIDTH'(BINC);
  assign linc_w   = I_W_decim ?
    AXI_ADDR_WIDTH'(last_inc(W_XSTRIDE, W_XSIZE / 2, W_XDIV)) :
    AXI_ADDR_WIDTH'(LINC);
  assign nburst_w = I_W_decim ? 32'(NBURST / 2) : 32'(NBURST);
  assign keep     = !I_W_decim || (!px_q[0] && !ln_q);

  // Pixel/line position since frame start selects the kept pixels.
  always_ff @(posedge I_ui_clk or posedge I_ui_rst) begin
    if (I_ui_rst) begin
      px_q <= '0;
      ln_q <= 1'b0;
    end else if (clr) begin
      px_q <= '0;
      ln_q <= 1'b0;
    end else if (I_W_wren) begin
      if (px_q == 16'(W_XSIZE - 1)) begin
        px_q <= '0;
        ln_q <= ~ln_q;
      end else begin
        px_q <= px_q + 16'd1;
      end
    end
  end
`else
  assign burst_w  = 16'(BURST);
  assign binc_w   = AXI_ADDR_WIDTH'(BINC);
  assign linc_w   = AXI_ADDR_WIDTH'(LINC);
  assign nburst_w = 32'(NBURST);
  assign keep     = 1'b1;
`endif

  assign fs_rise    = I_W_FS & ~fs_q;
  assign fs_evt     = fs_rise | pend_q;
  assign clr        = state_q == S_RST;
  assign pix_vld    = I_W_wren & keep & ~clr;
  assign full       = cnt_q == FC'(W_FIFO_DEPTH);
  assign empty      = cnt_q == '0;
  assign push       = word_vld & ~full & ~clr;
  assign pop        = (state_q == S_DATA) & I_fdma_wvalid & ~empty;
  assign bdone      = (state_q == S_DATA) & ~I_fdma_wbusy;
  assign xlast      = xdiv_q == 8'(W_XDIV - 1);
  assign last_burst = (bcnt_q + 32'd1) == nburst_w;

  wr_pix_pack #(
    .PIX_W (W_DATAWIDTH),
    .WORD_W(AXI_DATA_WIDTH)
  ) u_pack (
    .clk_i     (I_ui_clk),
    .rst_i     (I_ui_rst),
    .clr_i     (clr),
    .pix_vld_i (pix_vld),
    .pix_i     (I_W_data),
    .word_o    (word),
    .word_vld_o(word_vld)
  );

  always_comb begin
    state_d       = state_q;
    O_fdma_wareq  = 1'b0;
    O_fdma_wready = 1'b0;
    unique case (state_q)
      S_IDLE: if (fs_evt) state_d = S_RST;
      S_RST:  if (rcnt_q == 4'(RST_LEN - 1)) state_d = S_WAIT;
      S_WAIT: begin
        if (fs_evt) state_d = S_RST;
        else if (32'(cnt_q) >= 32'(burst_w)) state_d = S_REQ;
      end
      S_REQ: begin
        O_fdma_wareq = 1'b1;
        if (I_fdma_wbusy) state_d = S_DATA;
      end
      S_DATA: begin
        O_fdma_wready = ~empty;
        if (!I_fdma_wbusy) state_d = last_burst ? S_IDLE : S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_ui_clk or posedge I_ui_rst) begin
    if (I_ui_rst) begin
      state_q <= S_IDLE;
      fs_q    <= 1'b0;
      pend_q  <= 1'b0;
      rcnt_q  <= '0;
      sync_q  <= '0;
      bufn_q  <= '0;
      waddr_q <= '0;
      bcnt_q  <= '0;
      xdiv_q  <= '0;
      wsize_q <= '0;
      wbuf_q  <= '0;
      irq_q   <= '0;
    end else begin
      state_q <= state_d;
      fs_q    <= I_W_FS;
      // A sync seen mid-burst is held until the burst finishes.
      if (state_q != S_RST && state_d == S_RST) pend_q <= 1'b0;
      else if (fs_rise && (state_q == S_REQ || state_q == S_DATA))
        pend_q <= 1'b1;
      rcnt_q <= clr ? rcnt_q + 4'd1 : 4'd0;
      if (state_q == S_IDLE && fs_evt)
        sync_q <= (sync_q == 8'(W_BUFSIZE - 1)) ? 8'd0 : sync_q + 8'd1;
      if (clr) begin
        bufn_q  <= I_W_buf;
        waddr_q <= '0;
        bcnt_q  <= '0;
        xdiv_q  <= '0;
        wsize_q <= burst_w;
      end else if (bdone) begin
        waddr_q <= waddr_q + (xlast ? linc_w : binc_w);
        xdiv_q  <= xlast ? 8'd0 : xdiv_q + 8'd1;
        bcnt_q  <= bcnt_q + 32'd1;
      end
      if (bdone && last_burst) begin
        wbuf_q <= bufn_q;
        irq_q  <= 6'(IRQ_LEN);
      end else if (irq_q != '0) begin
        irq_q <= irq_q - 6'd1;
      end
    end
  end

  always_ff @(posedge I_ui_clk or posedge I_ui_rst) begin
    if (I_ui_rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wp_q <= (wp_q == FLAST) ? '0 : wp_q + 1'b1;
      if (pop)  rp_q <= (rp_q == FLAST) ? '0 : rp_q + 1'b1;
      cnt_q <= cnt_q + FC'(push) - FC'(pop);
      if (word_vld && full) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge I_ui_clk) begin
    if (push) mem_q[wp_q] <= word;
  end

  assign O_W_ovf      = ovf_q;
  assign O_W_sync_cnt = sync_q;
  assign O_fdma_waddr = AXI_ADDR_WIDTH'(W_BASEADDR) +
    ((AXI_ADDR_WIDTH'(bufn_q) << W_DSIZEBITS) | (waddr_q & DMASK));
  assign O_fdma_wsize = wsize_q;
  assign O_fdma_wdata = empty ? '0 : mem_q[rp_q];
  assign O_fmda_wbuf  = wbuf_q;
  assign O_fdma_wirq  = irq_q != '0;

endmodule
